serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
// - Bit-serial unsigned subtractor: computes a - b - bin one bit per clock, LSB first, using a single borrow flop.
// - Inverse counterpart to the parallel adders in this library.
// - Trades WIDTH cycles of latency for one full-subtractor cell.
// - Sits in multi-cycle datapaths: start/busy on the request side, valid/out_ready on the result side.
// PARAMETERS
// - WIDTH  4  operand and result width in bits (>= 1)
// PORTS
// - clk        in   1      clock; all state updates on the rising edge
// - rst_n      in   1      asynchronous active-low reset
// - start      in   1      request; sampled only while busy = 0
// - a          in   WIDTH  minuend, captured when start is accepted
// - b          in   WIDTH  subtrahend, captured when start is accepted
// - bin        in   1      borrow-in, captured when start is accepted
// - out_ready  in   1      consumer accepts the result while valid = 1
// - busy       out  1      high in RUN and DONE
// - valid      out  1      result available (DONE state)
// - diff       out  WIDTH  (a - b - bin) mod 2^WIDTH; meaningful only while valid = 1
// - bout       out  1      final borrow-out: 1 iff a < b + bin (unsigned)
// BEHAVIOUR
// - Reset (async, rst_n = 0):
//   - state = IDLE; busy, valid, bout, diff, bit counter and operand shift registers all 0.
//   - Reset asserted mid-RUN or mid-DONE discards the operation immediately; no result is produced.
// - FSM states: IDLE, RUN, DONE.
// - IDLE:
//   - start = 1 at edge k: capture a and b into shift registers, load borrow flop with bin, clear counter, go to RUN.
//   - start = 0: remain in IDLE.
// - RUN, per edge:
//   - d = a_sh[0] ^ b_sh[0] ^ br.
//   - br' = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br).
//   - Shift d into diff from the MSB end; shift a_sh and b_sh right by 1; increment counter.
// - RUN exit: on the edge processing bit WIDTH-1 (edge k+WIDTH), go to DONE with bout = br' and valid = 1.
//   - Latency from start acceptance to valid: exactly WIDTH edges.
// - DONE: diff, bout and valid are held stable until valid & out_ready is sampled at an edge; then go to IDLE with valid = 0 and busy = 0.
//   - diff and bout keep their last values in IDLE until the next start.
// - start while busy = 1 (RUN or DONE) is ignored, including in the DONE cycle where out_ready = 1.
//   - Earliest next acceptance is the edge after returning to IDLE.
// - Inputs a, b and bin may change freely after the accepting edge.
// - Width rules: unsigned modular arithmetic; no overflow flag; bout is the only out-of-range indication.
// TESTING
// - WIDTH=4, a=9, b=3, bin=0, out_ready=1 -> valid at edge k+4; diff=6, bout=0; busy drops the following edge.
// - a=3, b=9, bin=0 -> diff=4'hA, bout=1.
// - a=0, b=0, bin=1 -> diff=4'hF, bout=1.
// - a=5, b=5, bin=0 -> diff=0, bout=0.
// - out_ready=0 for 5 cycles in DONE, with start pulsed during RUN and DONE -> valid/diff/bout held and no restart; raise out_ready -> IDLE next edge; next start is accepted normally.
// - rst_n low for 1 cycle mid-RUN (after 2 bits) -> all outputs 0 asynchronously, state IDLE; subsequent a=12, b=7, bin=1 -> diff=4, bout=0.
// - Exhaustive WIDTH=4 sweep (all a, b, bin), back-to-back starts, random out_ready stalls -> every result matches (a-b-bin) mod 16 and the borrow model; exactly one valid handshake per accepted start.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell plus a borrow flop; result valid WIDTH edges after start.
// Result is held in DONE until valid & out_ready; start is ignored while busy.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             out_ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_n;
  logic [WIDTH-1:0] d_ext;

  assign d     = a_sh[0] ^ b_sh[0] ^ br;
  assign br_n  = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);
  assign d_ext = WIDTH'(d);

  assign busy  = (state != IDLE);
  assign valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // each result bit enters at the MSB so bit 0 lands in diff[0] after WIDTH shifts
          diff <= (diff >> 1) | (d_ext << (WIDTH - 1));
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_n;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bout  <= br_n;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             bin_i;
  logic             out_ready;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int checks;
  int errors;
  int hs;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a_i),
    .b         (b_i),
    .bin       (bin_i),
    .out_ready (out_ready),
    .busy      (busy),
    .valid     (valid),
    .diff      (diff),
    .bout      (bout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial hs = 0;
  always @(posedge clk) begin
    if (rst_n && valid && out_ready) hs <= hs + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at #1 after a clock edge, with the DUT idle and out_ready = 1.
  task automatic run_directed(input string tag, input logic [3:0] av, input logic [3:0] bv,
                              input logic cv, input logic [3:0] exp_d, input logic exp_b);
    a_i   = av;
    b_i   = bv;
    bin_i = cv;
    start = 1'b1;
    step();
    start = 1'b0;
    a_i   = 4'h0;
    b_i   = 4'hF;
    bin_i = ~cv;
    check({tag, "_busy_k"}, 32'(busy), 32'd1);
    repeat (WIDTH) begin
      check({tag, "_early_valid"}, 32'(valid), 32'd0);
      step();
    end
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(exp_d));
    check({tag, "_bout"}, 32'(bout), 32'(exp_b));
    step();
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    check({tag, "_valid_drop"}, 32'(valid), 32'd0);
    check({tag, "_diff_kept"}, 32'(diff), 32'(exp_d));
  endtask

  initial begin
    int lat;
    int e;
    int hs_base;
    logic [3:0] exp_d;
    logic       exp_b;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a_i       = '0;
    b_i       = '0;
    bin_i     = 1'b0;
    out_ready = 1'b1;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    run_directed("t9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
    run_directed("t3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
    run_directed("t0m0b", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
    run_directed("t5m5", 4'd5, 4'd5, 1'b0, 4'd0, 1'b0);

    // stalled consumer, with start held high throughout RUN and DONE
    out_ready = 1'b0;
    a_i   = 4'd10;
    b_i   = 4'd4;
    bin_i = 1'b0;
    start = 1'b1;
    step();
    a_i = 4'd1;
    b_i = 4'd2;
    repeat (WIDTH) step();
    for (int s = 0; s < 6; s++) begin
      check("stall_valid", 32'(valid), 32'd1);
      check("stall_diff", 32'(diff), 32'd6);
      check("stall_bout", 32'(bout), 32'd0);
      if (s < 5) step();
    end
    out_ready = 1'b1;
    step();
    check("stall_release_busy", 32'(busy), 32'd0);
    check("stall_release_diff", 32'(diff), 32'd6);
    start = 1'b0;
    run_directed("after_stall", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);

    // reset after two bits of a run
    a_i   = 4'd15;
    b_i   = 4'd1;
    bin_i = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_bout", 32'(bout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_busy", 32'(busy), 32'd0);
    run_directed("t12m7b", 4'd12, 4'd7, 1'b1, 4'd4, 1'b0);

    // exhaustive sweep with random consumer stalls
    hs_base = hs;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          e     = av - bv - cv;
          exp_d = 4'(e & 15);
          exp_b = (av < bv + cv);
          a_i   = 4'(av);
          b_i   = 4'(bv);
          bin_i = cv[0];
          start = 1'b1;
          step();
          start = 1'b0;
          a_i   = 4'($urandom_range(0, 15));
          b_i   = 4'($urandom_range(0, 15));
          bin_i = 1'($urandom_range(0, 1));
          lat = 0;
          while (!valid && lat < 10) begin
            step();
            lat++;
          end
          check("sweep_latency", 32'(lat), 32'd4);
          check("sweep_diff", 32'(diff), 32'(exp_d));
          check("sweep_bout", 32'(bout), 32'(exp_b));
          for (int s = 0; s < 20; s++) begin
            out_ready = (s == 19) ? 1'b1 : 1'($urandom_range(0, 1));
            step();
            if (!valid) break;
            check("sweep_hold_diff", 32'(diff), 32'(exp_d));
          end
          check("sweep_idle", 32'(busy), 32'd0);
        end
      end
    end
    check("sweep_handshakes", 32'(hs - hs_base), 32'd512);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
